// File: rtl/inst_encoder_loader_pkg.sv
// Shared MIPS opcode/funct values, internal INST_* codes and the record-to-word encoder.
// The decoder uses the same constants, so the two stay consistent.
package inst_encoder_loader_pkg;

  localparam logic [5:0] OPCODE_SPECIAL = 6'h00;
  localparam logic [5:0] OPCODE_J       = 6'h02;
  localparam logic [5:0] OPCODE_JAL     = 6'h03;
  localparam logic [5:0] OPCODE_BEQ     = 6'h04;
  localparam logic [5:0] OPCODE_ADDI    = 6'h08;
  localparam logic [5:0] OPCODE_ADDIU   = 6'h09;
  localparam logic [5:0] OPCODE_ORI     = 6'h0D;
  localparam logic [5:0] OPCODE_LUI     = 6'h0F;
  localparam logic [5:0] OPCODE_LB      = 6'h20;
  localparam logic [5:0] OPCODE_LW      = 6'h23;
  localparam logic [5:0] OPCODE_SB      = 6'h28;
  localparam logic [5:0] OPCODE_SW      = 6'h2B;
  localparam logic [5:0] OPCODE_HLT     = 6'h3F;

  localparam logic [5:0] FUNCT_JR   = 6'h08;
  localparam logic [5:0] FUNCT_ADDU = 6'h21;
  localparam logic [5:0] FUNCT_SUBU = 6'h23;
  localparam logic [5:0] FUNCT_SLT  = 6'h2A;

  typedef enum logic [5:0] {
    INST_NOP   = 6'd0,
    INST_ADDU  = 6'd1,
    INST_SUBU  = 6'd2,
    INST_SLT   = 6'd3,
    INST_JR    = 6'd4,
    INST_ORI   = 6'd5,
    INST_LW    = 6'd6,
    INST_SW    = 6'd7,
    INST_BEQ   = 6'd8,
    INST_ADDI  = 6'd9,
    INST_ADDIU = 6'd10,
    INST_LB    = 6'd11,
    INST_SB    = 6'd12,
    INST_LUI   = 6'd13,
    INST_J     = 6'd14,
    INST_JAL   = 6'd15,
    INST_HLT   = 6'd16
  } inst_e;

  typedef struct packed {
    logic [5:0]  inst;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [15:0] imm;
    logic [25:0] target;
  } rec_t;

  typedef struct packed {
    logic        known;
    logic [31:0] word;
  } enc_t;

  // shamt is carried in the record but never encoded: every supported R-type writes 0 there.
  function automatic enc_t encode(rec_t r);
    enc_t e;
    e.known = 1'b1;
    e.word  = '0;
    case (r.inst)
      INST_NOP:   e.word = '0;
      INST_ADDU:  e.word = {OPCODE_SPECIAL, r.rs, r.rt, r.rd, 5'd0, FUNCT_ADDU};
      INST_SUBU:  e.word = {OPCODE_SPECIAL, r.rs, r.rt, r.rd, 5'd0, FUNCT_SUBU};
      INST_SLT:   e.word = {OPCODE_SPECIAL, r.rs, r.rt, r.rd, 5'd0, FUNCT_SLT};
      INST_JR:    e.word = {OPCODE_SPECIAL, r.rs, 15'd0, FUNCT_JR};
      INST_ORI:   e.word = {OPCODE_ORI, r.rs, r.rt, r.imm};
      INST_LW:    e.word = {OPCODE_LW, r.rs, r.rt, r.imm};
      INST_SW:    e.word = {OPCODE_SW, r.rs, r.rt, r.imm};
      INST_BEQ:   e.word = {OPCODE_BEQ, r.rs, r.rt, r.imm};
      INST_ADDI:  e.word = {OPCODE_ADDI, r.rs, r.rt, r.imm};
      INST_ADDIU: e.word = {OPCODE_ADDIU, r.rs, r.rt, r.imm};
      INST_LB:    e.word = {OPCODE_LB, r.rs, r.rt, r.imm};
      INST_SB:    e.word = {OPCODE_SB, r.rs, r.rt, r.imm};
      INST_LUI:   e.word = {OPCODE_LUI, 5'd0, r.rt, r.imm};
      INST_J:     e.word = {OPCODE_J, r.target};
      INST_JAL:   e.word = {OPCODE_JAL, r.target};
      INST_HLT:   e.word = {OPCODE_HLT, 26'd0};
      default:    e.known = 1'b0;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/inst_encoder_loader_if.sv
// Record input channel plus instruction-memory write port of the loader.
// master = record producer / memory side, slave = the loader itself.
interface inst_encoder_loader_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [5:0]        in_inst;
  logic [4:0]        in_rs;
  logic [4:0]        in_rt;
  logic [4:0]        in_rd;
  logic [4:0]        in_shamt;
  logic [15:0]       in_imm;
  logic [25:0]       in_target;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              imem_ready;

  modport master (
    output in_valid, in_inst, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target, imem_ready,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  in_valid, in_inst, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target, imem_ready,
    output in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/inst_encoder_loader_sync_fifo.sv
// Small synchronous FIFO with flush; flush wins over push and pop in the same cycle.
module inst_encoder_loader_sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);
  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW:0]      r_wptr;
  logic [PW:0]      r_rptr;
  logic             w_push;
  logic             w_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[PW] != r_rptr[PW]) && (r_wptr[PW-1:0] == r_rptr[PW-1:0]);
  assign w_push  = i_push && !o_full && !i_flush;
  assign w_pop   = i_pop && !o_empty && !i_flush;
  assign o_rdata = r_mem[r_rptr[PW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (i_flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[PW-1:0]] <= i_wdata;
  end
endmodule

// File: rtl/inst_encoder_loader.sv
// Encodes decoded instruction records into MIPS words and streams them into instruction
// memory at consecutive word addresses until an HLT word has been written.
module inst_encoder_loader
  import inst_encoder_loader_pkg::*;
#(
  parameter int unsigned       ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
  parameter int unsigned       FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_start,
  inst_encoder_loader_if.slave bus,
  output logic                 o_done,
  output logic [7:0]           o_err_cnt
);
  rec_t              w_rec;
  enc_t              w_enc;
  logic [31:0]       w_head;
  logic              w_full;
  logic              w_empty;
  logic              w_accept;
  logic              w_wr;
  logic              w_hlt_wr;
  logic              w_flush;
  logic              w_push;
  logic              r_run;
  logic              r_done;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_err_cnt;

  assign w_rec = '{inst: bus.in_inst, rs: bus.in_rs, rt: bus.in_rt, rd: bus.in_rd,
                   shamt: bus.in_shamt, imm: bus.in_imm, target: bus.in_target};
  assign w_enc = encode(w_rec);

  // r_run keeps in_ready low while reset is asserted, even though the FIFO reads empty.
  assign bus.in_ready   = r_run && !w_full && !r_done && !i_start;
  assign bus.imem_we    = !w_empty;
  assign bus.imem_addr  = r_addr;
  assign bus.imem_wdata = w_empty ? 32'h0 : w_head;

  assign w_accept = bus.in_valid && bus.in_ready;
  assign w_wr     = bus.imem_we && bus.imem_ready;
  assign w_hlt_wr = w_wr && (w_head[31:26] == OPCODE_HLT);
  assign w_flush  = i_start || w_hlt_wr;
  assign w_push   = w_accept && w_enc.known;

  inst_encoder_loader_sync_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_wr),
    .i_flush (w_flush),
    .i_wdata (w_enc.word),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run     <= 1'b0;
      r_done    <= 1'b0;
      r_addr    <= BASE_ADDR;
      r_err_cnt <= 8'd0;
    end else begin
      r_run <= 1'b1;
      if (i_start) begin
        r_done    <= 1'b0;
        r_addr    <= BASE_ADDR;
        r_err_cnt <= 8'd0;
      end else begin
        if (w_hlt_wr) r_done <= 1'b1;
        if (w_wr)     r_addr <= r_addr + ADDR_W'(4);
        if (w_accept && !w_enc.known && (r_err_cnt != 8'hFF)) r_err_cnt <= r_err_cnt + 8'd1;
      end
    end
  end

  assign o_done    = r_done;
  assign o_err_cnt = r_err_cnt;
endmodule

// File: tb/tb_inst_encoder_loader.sv
// Directed and randomized checks of inst_encoder_loader against a table-driven encoding model.
module tb_inst_encoder_loader;
  localparam int unsigned DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       done;
  logic [7:0] err_cnt;

  inst_encoder_loader_if #(.ADDR_W(32)) bus();

  inst_encoder_loader #(
    .ADDR_W     (32),
    .BASE_ADDR  (32'h0),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_start   (start),
    .bus       (bus),
    .o_done    (done),
    .o_err_cnt (err_cnt)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail = 0;
  logic [63:0] obs_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] exp_addr = 32'h0;
  int          exp_err = 0;
  bit          hlt_queued = 1'b0;
  bit          rand_ready = 1'b0;
  logic [31:0] last_data;
  logic [31:0] last_addr;

  // Every write handshake seen by memory, as {addr, data}.
  always @(negedge clk)
    if (rst_n && bus.imem_we && bus.imem_ready) obs_q.push_back({bus.imem_addr, bus.imem_wdata});

  initial forever begin
    @(posedge clk);
    #2;
    if (rand_ready) bus.imem_ready = 1'($urandom_range(0, 1));
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // MIPS field layout computed from opcode/funct tables; shamt never appears in the word.
  function automatic bit model_enc(input logic [31:0] code, rs, rt, rd, imm, tgt,
                                   output logic [31:0] w);
    logic [31:0] r3;
    logic [31:0] it;
    r3 = (rs << 21) | (rt << 16) | (rd << 11);
    it = (rs << 21) | (rt << 16) | imm;
    model_enc = 1'b1;
    case (code)
      0:       w = 32'h0;
      1:       w = r3 | 32'h21;
      2:       w = r3 | 32'h23;
      3:       w = r3 | 32'h2A;
      4:       w = (rs << 21) | 32'h08;
      5:       w = (32'h0D << 26) | it;
      6:       w = (32'h23 << 26) | it;
      7:       w = (32'h2B << 26) | it;
      8:       w = (32'h04 << 26) | it;
      9:       w = (32'h08 << 26) | it;
      10:      w = (32'h09 << 26) | it;
      11:      w = (32'h20 << 26) | it;
      12:      w = (32'h28 << 26) | it;
      13:      w = (32'h0F << 26) | (rt << 16) | imm;
      14:      w = (32'h02 << 26) | tgt;
      15:      w = (32'h03 << 26) | tgt;
      16:      w = 32'h3F << 26;
      default: begin w = 32'h0; model_enc = 1'b0; end
    endcase
  endfunction

  // Anything accepted after an HLT never reaches memory: it is flushed or refused.
  task automatic model_push(input logic [31:0] code, rs, rt, rd, imm, tgt);
    logic [31:0] w;
    bit          ok;
    ok = model_enc(code, rs, rt, rd, imm, tgt, w);
    if (!ok) begin
      if (exp_err < 255) exp_err++;
    end else if (!hlt_queued) begin
      exp_q.push_back(w);
      if (code == 16) hlt_queued = 1'b1;
    end
  endtask

  task automatic drive_rec(input logic [31:0] code, rs, rt, rd, sh, imm, tgt);
    bus.in_inst   = 6'(code);
    bus.in_rs     = 5'(rs);
    bus.in_rt     = 5'(rt);
    bus.in_rd     = 5'(rd);
    bus.in_shamt  = 5'(sh);
    bus.in_imm    = 16'(imm);
    bus.in_target = 26'(tgt);
  endtask

  // Called and returns at posedge+1.
  task automatic send(input logic [31:0] code, rs, rt, rd, sh, imm, tgt, input bit must);
    int n;
    bit acc;
    drive_rec(code, rs, rt, rd, sh, imm, tgt);
    bus.in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    acc = bus.in_ready;
    if (must) check("send_accept", 64'(acc), 64'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    if (acc) model_push(code, rs, rt, rd, imm, tgt);
  endtask

  task automatic drain_check(input string tag);
    int n;
    logic [63:0] o;
    logic [31:0] e;
    n = 0;
    while (obs_q.size() < exp_q.size() && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check({tag, "_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      check({tag, "_addr"}, 64'(o[63:32]), 64'(exp_addr));
      check({tag, "_data"}, 64'(o[31:0]), 64'(e));
      last_addr = o[63:32];
      last_data = o[31:0];
      exp_addr += 4;
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  initial begin
    logic [31:0] bc[6];
    logic [31:0] brs[6];
    logic [31:0] brt[6];
    logic [31:0] bimm[6];
    logic [31:0] code;
    int          acc;
    int          idx;
    bit          hit;
    logic [31:0] snap_addr;
    logic [31:0] snap_data;

    bus.in_valid = 1'b0;
    bus.imem_ready = 1'b1;
    drive_rec(0, 0, 0, 0, 0, 0, 0);

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    check("rst_we", 64'(bus.imem_we), 64'd0);
    check("rst_addr", 64'(bus.imem_addr), 64'h0);
    check("rst_wdata", 64'(bus.imem_wdata), 64'h0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err_cnt), 64'd0);
    @(posedge clk);
    #1;
    check("rst_in_ready", 64'(bus.in_ready), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed encodes
    send(1, 1, 2, 3, 0, 0, 0, 1'b1);
    drain_check("addu");
    check("addu_lit", 64'(last_data), 64'h00221821);
    check("addu_at0", 64'(last_addr), 64'h0);
    send(5, 0, 1, 0, 0, 32'h1234, 0, 1'b1);
    drain_check("ori");
    check("ori_lit", 64'(last_data), 64'h34011234);
    check("ori_at4", 64'(last_addr), 64'h4);
    send(13, 7, 5, 0, 0, 32'hABCD, 0, 1'b1);
    drain_check("lui");
    check("lui_lit", 64'(last_data), 64'h3C05ABCD);
    send(1, 4, 5, 6, 9, 0, 0, 1'b1);
    drain_check("shamt");
    check("shamt_zero", 64'(last_data[10:6]), 64'd0);
    send(14, 0, 0, 0, 0, 0, 32'h100, 1'b1);
    drain_check("j");
    check("j_lit", 64'(last_data), 64'h08000100);
    send(8, 1, 2, 0, 0, 32'hFFFF, 0, 1'b1);
    drain_check("beq");
    check("beq_lit", 64'(last_data), 64'h1022FFFF);

    // Randomized records with random memory backpressure
    rand_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 9) == 0) code = $urandom_range(17, 63);
      else code = $urandom_range(0, 15);
      send(code, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
           $urandom_range(0, 31), $urandom_range(0, 65535), $urandom_range(0, 32'h3FFFFFF),
           1'b1);
    end
    drain_check("rand");
    check("rand_err", 64'(err_cnt), 64'(exp_err));
    rand_ready = 1'b0;
    @(posedge clk);
    #1;

    // Backpressure: memory stalled for 10 cycles, 6 records offered
    bus.imem_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bc[i]   = $urandom_range(5, 12);
      brs[i]  = $urandom_range(0, 31);
      brt[i]  = $urandom_range(0, 31);
      bimm[i] = $urandom_range(0, 65535);
    end
    acc = 0;
    idx = 0;
    drive_rec(bc[0], brs[0], brt[0], 0, 0, bimm[0], 0);
    bus.in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      hit = bus.in_valid && bus.in_ready;
      @(posedge clk);
      #1;
      if (hit) begin
        model_push(bc[idx], brs[idx], brt[idx], 0, bimm[idx], 0);
        acc++;
        idx++;
        if (idx < 6) drive_rec(bc[idx], brs[idx], brt[idx], 0, 0, bimm[idx], 0);
        else bus.in_valid = 1'b0;
      end
    end
    bus.in_valid = 1'b0;
    check("bp_accepted", 64'(acc), 64'(DEPTH));
    check("bp_in_ready", 64'(bus.in_ready), 64'd0);
    check("bp_we", 64'(bus.imem_we), 64'd1);
    check("bp_addr", 64'(bus.imem_addr), 64'(exp_addr));
    check("bp_head", 64'(bus.imem_wdata), 64'(exp_q[0]));
    snap_addr = bus.imem_addr;
    snap_data = bus.imem_wdata;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check("bp_addr_hold", 64'(bus.imem_addr), 64'(snap_addr));
    check("bp_data_hold", 64'(bus.imem_wdata), 64'(snap_data));
    bus.imem_ready = 1'b1;
    drain_check("bp");

    // HLT stops the stream; a record right behind it is never written
    send(1, 1, 2, 3, 0, 0, 0, 1'b1);
    send(16, 0, 0, 0, 0, 0, 0, 1'b1);
    send(5, 0, 1, 0, 0, 32'h5555, 0, 1'b0);
    drain_check("hlt");
    check("hlt_lit", 64'(last_data), 64'hFC000000);
    check("hlt_done", 64'(done), 64'd1);
    check("hlt_in_ready", 64'(bus.in_ready), 64'd0);
    check("hlt_we", 64'(bus.imem_we), 64'd0);

    // start pulse restarts at BASE_ADDR
    start = 1'b1;
    @(negedge clk);
    check("start_in_ready", 64'(bus.in_ready), 64'd0);
    @(posedge clk);
    #1;
    start = 1'b0;
    exp_addr = 32'h0;
    exp_err = 0;
    hlt_queued = 1'b0;
    check("start_addr", 64'(bus.imem_addr), 64'h0);
    check("start_done", 64'(done), 64'd0);
    check("start_err", 64'(err_cnt), 64'd0);
    send(5, 0, 1, 0, 0, 32'h1234, 0, 1'b1);
    drain_check("restart");
    check("restart_at0", 64'(last_addr), 64'h0);

    // Unknown codes: counted, never written, saturating
    send(40, 1, 2, 3, 0, 0, 0, 1'b1);
    drain_check("unk");
    check("unk_err", 64'(err_cnt), 64'(exp_err));
    for (int i = 0; i < 260; i++) send($urandom_range(17, 63), 0, 0, 0, 0, 0, 0, 1'b1);
    drain_check("sat");
    check("sat_err", 64'(err_cnt), 64'(exp_err));
    check("sat_255", 64'(err_cnt), 64'd255);

    // Reset in the middle of a stalled drain
    bus.imem_ready = 1'b0;
    send(1, 1, 1, 1, 0, 0, 0, 1'b1);
    send(5, 2, 2, 0, 0, 32'h77, 0, 1'b1);
    check("mid_we_pre", 64'(bus.imem_we), 64'd1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_we", 64'(bus.imem_we), 64'd0);
    check("mid_addr", 64'(bus.imem_addr), 64'h0);
    check("mid_err", 64'(err_cnt), 64'd0);
    exp_q.delete();
    obs_q.delete();
    exp_addr = 32'h0;
    exp_err = 0;
    hlt_queued = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.imem_ready = 1'b1;
    @(posedge clk);
    #1;
    send(15, 0, 0, 0, 0, 0, 32'h2ABCDEF, 1'b1);
    drain_check("post_rst");
    check("post_rst_at0", 64'(last_addr), 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
